// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch flash bridge.
package ifetch_pkg;

    localparam int unsigned TAG_W  = 30;
    localparam int unsigned WORD_W = 32;

    // RISC-V "addi x0, x0, 0", the canonical no-op instruction word.
    localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEM_REQ,
        ST_DEM_WAIT,
        ST_PF_REQ,
        ST_PF_WAIT
    } fetch_state_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [WORD_W-1:0] data;
    } buf_entry_t;

    // Sequential word tag; wraps from all-ones to zero.
    function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
        return t + TAG_W'(1);
    endfunction

endpackage

// File: rtl/ifetch_buf_entry.sv
// One-word fetch buffer: valid/tag/data register with load, clear and tag compare.
module ifetch_buf_entry
    import ifetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [TAG_W-1:0]  load_tag,
    input  logic [WORD_W-1:0] load_data,
    input  logic [TAG_W-1:0]  cmp_tag,
    output buf_entry_t        entry,
    output logic              hit_c
);

    // Load wins over clear so a same-cycle refill is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry <= '0;
        end else if (load) begin
            entry.valid <= 1'b1;
            entry.tag   <= load_tag;
            entry.data  <= load_data;
        end else if (clear) begin
            entry.valid <= 1'b0;
        end
    end

    assign hit_c = entry.valid && (entry.tag == cmp_tag);

endmodule

// File: rtl/ifetch_flash_bridge.sv
// Instruction-fetch responder with a current word buffer and a sequential
// prefetch buffer, backed by a single-outstanding flash read master.
module ifetch_flash_bridge
    import ifetch_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter bit          PREFETCH_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       inst_addr,
    output logic [31:0]       inst_data,
    output logic              inst_stall,
    output logic [ADDR_W-1:0] flash_address,
    output logic              flash_read,
    input  logic              flash_waitrequest,
    input  logic              flash_readdatavalid,
    input  logic [31:0]       flash_readdata
);

    fetch_state_t     state;
    logic [TAG_W-1:0] rd_tag;

    buf_entry_t cur;
    buf_entry_t nxt;
    logic       cur_hit;
    logic       nxt_match;

    logic [TAG_W-1:0] req_tag;
    logic             nxt_hit;
    logic             miss;
    logic             rsp_dem;
    logic             rsp_pf;
    logic             pf_claim;
    logic             pf_redirect;
    logic             cur_fill;
    logic             nxt_fill;
    logic             promote;

    logic              cur_load;
    logic [TAG_W-1:0]  cur_load_tag;
    logic [WORD_W-1:0] cur_load_data;
    logic              nxt_clear;

    logic unused_bits;

    function automatic logic [ADDR_W-1:0] faddr(input logic [TAG_W-1:0] t);
        return t[ADDR_W-1:0];
    endfunction

    assign req_tag     = inst_addr[31:2];
    assign unused_bits = ^inst_addr[1:0] ^ cur.valid ^ (^cur.tag) ^ nxt.valid;

    // Hit path: CUR has priority, NXT only counts when CUR misses.
    assign nxt_hit    = !cur_hit && nxt_match;
    assign miss       = !cur_hit && !nxt_match;
    assign inst_stall = miss;
    assign inst_data  = nxt_hit ? nxt.data : cur.data;

    // Response routing; responses outside the wait states are stale and dropped.
    assign rsp_dem     = flash_readdatavalid && (state == ST_DEM_WAIT);
    assign rsp_pf      = flash_readdatavalid && (state == ST_PF_WAIT);
    assign pf_claim    = rsp_pf && miss && (req_tag == rd_tag);
    assign pf_redirect = rsp_pf && miss && (req_tag != rd_tag);
    assign cur_fill    = rsp_dem || pf_claim;
    assign nxt_fill    = rsp_pf && !miss;
    assign promote     = nxt_hit && !cur_fill;

    assign cur_load      = cur_fill || promote;
    assign cur_load_tag  = cur_fill ? rd_tag : nxt.tag;
    assign cur_load_data = cur_fill ? flash_readdata : nxt.data;
    assign nxt_clear     = promote || cur_fill;

    ifetch_buf_entry u_cur (
        .clk       (clk),
        .reset     (reset),
        .load      (cur_load),
        .clear     (1'b0),
        .load_tag  (cur_load_tag),
        .load_data (cur_load_data),
        .cmp_tag   (req_tag),
        .entry     (cur),
        .hit_c     (cur_hit)
    );

    ifetch_buf_entry u_nxt (
        .clk       (clk),
        .reset     (reset),
        .load      (nxt_fill),
        .clear     (nxt_clear),
        .load_tag  (rd_tag),
        .load_data (flash_readdata),
        .cmp_tag   (req_tag),
        .entry     (nxt),
        .hit_c     (nxt_match)
    );

    // Fetch FSM and registered flash read master (one read in flight).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            rd_tag        <= '0;
            flash_read    <= 1'b0;
            flash_address <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (miss) begin
                        state         <= ST_DEM_REQ;
                        rd_tag        <= req_tag;
                        flash_read    <= 1'b1;
                        flash_address <= faddr(req_tag);
                    end else if (PREFETCH_EN && promote) begin
                        state         <= ST_PF_REQ;
                        rd_tag        <= next_tag(req_tag);
                        flash_read    <= 1'b1;
                        flash_address <= faddr(next_tag(req_tag));
                    end
                end
                ST_DEM_REQ: begin
                    if (!flash_waitrequest) begin
                        state      <= ST_DEM_WAIT;
                        flash_read <= 1'b0;
                    end
                end
                ST_DEM_WAIT: begin
                    if (rsp_dem) begin
                        if (PREFETCH_EN) begin
                            state         <= ST_PF_REQ;
                            rd_tag        <= next_tag(rd_tag);
                            flash_read    <= 1'b1;
                            flash_address <= faddr(next_tag(rd_tag));
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_PF_REQ: begin
                    if (!flash_waitrequest) begin
                        state      <= ST_PF_WAIT;
                        flash_read <= 1'b0;
                    end
                end
                ST_PF_WAIT: begin
                    if (pf_redirect) begin
                        state         <= ST_DEM_REQ;
                        rd_tag        <= req_tag;
                        flash_read    <= 1'b1;
                        flash_address <= faddr(req_tag);
                    end else if (rsp_pf) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    flash_read <= 1'b0;
                end
            endcase
        end
    end

endmodule
